regfile_sweep: RTL
==================

Name: regfile_sweep

Overview:
- Parametrised successor to the CPU's 3-port register file.
- Adds configurable width and depth, per-byte write enables (for LWL/LWR-style partial writes) and a registered debug read port.
- Reset clears the array with a sequential one-entry-per-cycle sweep, so the array can infer as RAM with no per-entry reset.
- Sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two, ≥ 4. Address width AW = clog2(DEPTH).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  write enable
- wbe  in  WIDTH/8  byte enables; bit i gates wd[8i+7:8i]
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra1  in  AW  read address 1
- ra2  in  AW  read address 2
- rd1  out  WIDTH  read data 1, combinational
- rd2  out  WIDTH  read data 2, combinational
- dbg_ra  in  AW  debug read address
- dbg_q  out  WIDTH  registered debug data
- busy  out  1  high while reset is asserted or the clear sweep is running

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- FSM states: CLEAR, READY.
- While reset = 1:
  - state <= CLEAR; sweep counter cnt <= 0; dbg_q <= 0; busy = 1.
  - No array write takes place.
- In CLEAR with reset = 0:
  - Each cycle writes 0 to rf[cnt], then cnt <= cnt + 1.
  - When cnt = DEPTH-1 is written, state <= READY on that same edge.
  - Sweep length is exactly DEPTH cycles after reset deasserts, so busy falls on the DEPTH-th rising edge after deassertion.
- busy = (state == CLEAR), combinational from state. It is 1 out of reset.
- While busy:
  - rd1, rd2 = 0.
  - we is ignored; the write is dropped, not queued.
  - dbg_q is loaded with 0.
- Reset reasserted mid-sweep: the sweep restarts from cnt = 0. There is no partial-clear state.
- In READY, write on rising edge if we = 1:
  - For each i with wbe[i] = 1: rf[wa] byte i <= wd byte i.
  - Bytes with wbe[i] = 0 are unchanged.
  - wbe = 0 is a no-op.
- ZERO_REG = 1:
  - Writes to wa = 0 are discarded.
  - Reads of address 0 (ra1, ra2, dbg_ra) return 0, including from dbg_q.
  - The sweep still writes rf[0].
- Reads: rd1 = rf[ra1], rd2 = rf[ra2], combinational, subject to the ZERO_REG and busy rules.
- Read during write to the same address without the feature macro: returns the pre-write value. The new value is visible the cycle after the edge.
- Debug port: dbg_q <= rf[dbg_ra] every rising edge (1-cycle latency). It reflects array contents before that same edge's write.
- No X may reach rd1, rd2 or dbg_q after busy falls.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd1/rd2 forward the merged write value when we = 1, not busy, ra == wa and the address is writable (wa ≠ 0 when ZERO_REG = 1).
  - Merged value: for each byte, wd byte if wbe[i] = 1, else current rf byte.
  - This is combinational, same cycle.
  - dbg_q is not bypassed.
- Undefined: no forwarding; reads return the pre-write value as above.

Test Plan:
- Sweep timing: DEPTH = 32; pulse reset for 3 cycles, release → busy stays 1 for exactly 32 edges then falls; rd1 of every address = 0 afterwards.
- Write ignored while busy: during the sweep, we = 1, wa = 5, wd = 32'hDEADBEEF, wbe = 4'hF → after the sweep rf[5] reads 0.
- Byte enables: in READY, write wa = 7, wd = 32'h11223344, wbe = 4'hF; then wd = 32'hAABBCCDD, wbe = 4'b0101 → rd1 (ra1 = 7) = 32'h11BB33DD.
- Zero register: ZERO_REG = 1, write wa = 0, wd = 32'hFFFFFFFF → rd2 (ra2 = 0) = 0 and dbg_q (dbg_ra = 0) = 0 next cycle.
- Restart and debug latency:
  - Reassert reset at sweep cnt = 10 → busy remains 1 for a full 32 edges after the new deassertion.
  - Write wa = 3, wd = 32'h5 → dbg_q (dbg_ra = 3) shows 32'h5 one edge after the write edge, not on it.
- Same-cycle read/write: same-cycle write/read of wa = ra1 = 9, wd = 32'hCAFEF00D, wbe = 4'hF, rf[9] previously 0 → rd1 = 32'hCAFEF00D with REGFILE_BYPASS_EN, 0 without it.

Source files
------------

// File: rtl/regfile_sweep_if.sv
// Register file bus: two combinational read ports, one byte-enabled write port,
// a registered debug read port and the clear-sweep busy flag.
interface regfile_sweep_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic              we;
  logic [NB-1:0]     wbe;
  logic [AW-1:0]     wa;
  logic [WIDTH-1:0]  wd;
  logic [AW-1:0]     ra1;
  logic [AW-1:0]     ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic [AW-1:0]     dbg_ra;
  logic [WIDTH-1:0]  dbg_q;
  logic              busy;

  modport master (
    output we, wbe, wa, wd, ra1, ra2, dbg_ra,
    input  rd1, rd2, dbg_q, busy
  );

  modport slave (
    input  we, wbe, wa, wd, ra1, ra2, dbg_ra,
    output rd1, rd2, dbg_q, busy
  );
endinterface

// File: rtl/regfile_sweep.sv
// Parametrised 3-port register file, cleared after reset by a one-entry-per-cycle sweep.
// Optional macro REGFILE_BYPASS_EN forwards the merged write value to rd1/rd2.
module regfile_sweep #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  regfile_sweep_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_d;
  logic [AW-1:0]    cnt, cnt_d;
  logic             busy;
  logic             clear_en;
  logic             write_en;
  logic [WIDTH-1:0] dbg_q;
  logic [WIDTH-1:0] rd1, rd2;

  // No per-entry reset here, so the array can map onto RAM
  logic [WIDTH-1:0] rf [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == CLEAR) begin
      cnt_d = cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1))
        state_d = READY;
    end
  end

  always_comb begin
    busy     = (state == CLEAR);
    clear_en = !reset && (state == CLEAR);
    write_en = !reset && (state == READY) && bus.we && !(ZR && (bus.wa == '0));
  end

  always_ff @(posedge clk) begin
    if (clear_en) begin
      rf[cnt] <= '0;
    end else if (write_en) begin
      for (int i = 0; i < NB; i++)
        if (bus.wbe[i])
          rf[bus.wa][8*i +: 8] <= bus.wd[8*i +: 8];
    end
  end

  // Samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset || busy || (ZR && (bus.dbg_ra == '0)))
      dbg_q <= '0;
    else
      dbg_q <= rf[bus.dbg_ra];
  end

`ifdef REGFILE_BYPASS_EN
  logic [WIDTH-1:0] merged;

  always_comb begin
    merged = rf[bus.wa];
    for (int i = 0; i < NB; i++)
      if (bus.wbe[i])
        merged[8*i +: 8] = bus.wd[8*i +: 8];
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!busy) begin
      if (write_en && (bus.ra1 == bus.wa))
        rd1 = merged;
      else if (!(ZR && (bus.ra1 == '0)))
        rd1 = rf[bus.ra1];
      if (write_en && (bus.ra2 == bus.wa))
        rd2 = merged;
      else if (!(ZR && (bus.ra2 == '0)))
        rd2 = rf[bus.ra2];
    end
  end
`else
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!busy) begin
      if (!(ZR && (bus.ra1 == '0)))
        rd1 = rf[bus.ra1];
      if (!(ZR && (bus.ra2 == '0)))
        rd2 = rf[bus.ra2];
    end
  end
`endif

  assign bus.rd1   = rd1;
  assign bus.rd2   = rd2;
  assign bus.dbg_q = dbg_q;
  assign bus.busy  = busy;
endmodule
